// File: rtl/dff_bank_module.sv
// dff_bank_module: register bank of six-NAND edge-triggered flip-flops evaluated one gate delay per U edge,
// with settle, oscillation, setup/hold and triode-off monitors.
module dff_bank_module #(
   parameter int WIDTH  = 12,
   parameter int SETTLE = 3,
   parameter int MAXOSC = 16,
   parameter int SETUP  = 2,
   parameter int HOLD   = 2
) (
   input  logic                             U,
   input  logic                             RESET,
   input  logic                             T,
   input  logic [WIDTH-1:0]                 D,
   input  logic                             _PC,
   input  logic                             _PS,
   input  logic                             _SC,
   output logic [WIDTH-1:0]                 Q,
   output logic [WIDTH-1:0]                 _Q,
   output logic [WIDTH-1:0]                 ga,
   output logic [WIDTH-1:0]                 gb,
   output logic [WIDTH-1:0]                 gc,
   output logic [WIDTH-1:0]                 gd,
   output logic [WIDTH-1:0]                 ge,
   output logic [WIDTH-1:0]                 gf,
   output logic [$clog2(6*WIDTH+1)-1:0]     nto,
   output logic                             settled,
   output logic                             oscerr,
   output logic                             setupviol
);
   localparam int NW = $clog2(6*WIDTH+1);
   localparam int QW = $clog2(SETTLE+1);
   localparam int OW = $clog2(MAXOSC+1);
   localparam int DW = $clog2(SETUP+1);
   localparam int TW = $clog2(HOLD+1);
   logic [WIDTH-1:0] ga_q, gb_q, gc_q, gd_q, ge_q, gf_q, ga_d, gb_d, gc_d, gd_d, ge_d, gf_d;
   logic [WIDTH-1:0] x, dlast_q;
   logic [NW-1:0]    nto_q, nto_d;
   logic [QW-1:0]    quiet_q, quiet_d;
   logic [OW-1:0]    unset_q, unset_d;
   logic [DW-1:0]    dage_q, dage_d;
   logic [TW-1:0]    tage_q, tage_d;
   logic             settled_q, settled_d, oscerr_q, oscerr_d, viol_q, viol_d, tlast_q;
   logic             chg, dchg, trise;
   // Every gate sees only the previous edge's gate outputs: one U of delay per gate.
   always_comb begin
      x         = D & {WIDTH{_SC}};
      ga_d      = ~(x & gb_q & {WIDTH{_PC}});
      gb_d      = ~(ga_q & {WIDTH{T}} & gc_q);
      gc_d      = ~({WIDTH{T}} & gd_q & {WIDTH{_PC}});
      gd_d      = ~(gc_q & ga_q & {WIDTH{_PS}});
      ge_d      = ~(gb_q & gf_q & {WIDTH{_PC}});
      gf_d      = ~(gc_q & ge_q & {WIDTH{_PS}});
      chg       = {ga_d, gb_d, gc_d, gd_d, ge_d, gf_d} != {ga_q, gb_q, gc_q, gd_q, ge_q, gf_q};
      nto_d     = NW'($countones({ga_q, gb_q, gc_q, gd_q, ge_q, gf_q}));
      quiet_d   = chg ? '0 : (quiet_q == QW'(SETTLE)) ? quiet_q : quiet_q + 1'b1;
      settled_d = quiet_d == QW'(SETTLE);
      unset_d   = settled_q ? '0 : (unset_q == OW'(MAXOSC)) ? unset_q : unset_q + 1'b1;
      oscerr_d  = oscerr_q | (unset_d == OW'(MAXOSC));
      dchg      = D != dlast_q;
      trise     = T & ~tlast_q;
      dage_d    = dchg ? '0 : (dage_q == DW'(SETUP)) ? dage_q : dage_q + 1'b1;
      tage_d    = trise ? '0 : (tage_q == TW'(HOLD)) ? tage_q : tage_q + 1'b1;
      viol_d    = viol_q | (trise & (dage_d < DW'(SETUP))) | (dchg & (tage_d < TW'(HOLD)));
   end
   always_ff @(posedge U or posedge RESET) begin
      if (RESET) begin
         ga_q      <= '1;
         gb_q      <= '1;
         gc_q      <= '1;
         gd_q      <= '0;
         ge_q      <= '1;
         gf_q      <= '0;
         nto_q     <= NW'(4*WIDTH);
         quiet_q   <= '0;
         unset_q   <= '0;
         dage_q    <= '0;
         tage_q    <= '0;
         settled_q <= 1'b0;
         oscerr_q  <= 1'b0;
         viol_q    <= 1'b0;
         tlast_q   <= 1'b0;
         dlast_q   <= '0;
      end else begin
         ga_q      <= ga_d;
         gb_q      <= gb_d;
         gc_q      <= gc_d;
         gd_q      <= gd_d;
         ge_q      <= ge_d;
         gf_q      <= gf_d;
         nto_q     <= nto_d;
         quiet_q   <= quiet_d;
         unset_q   <= unset_d;
         dage_q    <= dage_d;
         tage_q    <= tage_d;
         settled_q <= settled_d;
         oscerr_q  <= oscerr_d;
         viol_q    <= viol_d;
         tlast_q   <= T;
         dlast_q   <= D;
      end
   end
   assign ga        = ga_q;
   assign gb        = gb_q;
   assign gc        = gc_q;
   assign gd        = gd_q;
   assign ge        = ge_q;
   assign gf        = gf_q;
   assign Q         = gf_q;
   assign _Q        = ge_q;
   assign nto       = nto_q;
   assign settled   = settled_q;
   assign oscerr    = oscerr_q;
   assign setupviol = viol_q;
endmodule

// File: tb/tb_dff_bank_module.sv
// tb_dff_bank_module: directed and random stimulus checked against an edge-timestamp reference model.
module tb_dff_bank_module;
   localparam int W = 12, SETTLE = 3, MAXOSC = 16, SETUP = 2, HOLD = 2;
   localparam int NW = $clog2(6*W+1);
   localparam logic [W-1:0] ALL = '1;
   localparam logic [W-1:0] NONE = '0;
   logic u = 0, rst = 0, t = 0, pc = 1, ps = 1, sc = 1;
   logic [W-1:0] d = '0;
   logic [W-1:0] q, qn, ga, gb, gc, gd, ge, gf;
   logic [NW-1:0] nto;
   logic settled, oscerr, setupviol;
   int errors = 0, checks = 0;
   logic [W-1:0] mga, mgb, mgc, mgd, mge, mgf, mdlast;
   int mnto, n, last_chg, last_ok, last_d, last_t;
   logic msettled, moscerr, mviol, mtlast;

   dff_bank_module #(.WIDTH(W), .SETTLE(SETTLE), .MAXOSC(MAXOSC), .SETUP(SETUP), .HOLD(HOLD)) dut (
      .U(u), .RESET(rst), .T(t), .D(d), ._PC(pc), ._PS(ps), ._SC(sc),
      .Q(q), ._Q(qn), .ga(ga), .gb(gb), .gc(gc), .gd(gd), .ge(ge), .gf(gf),
      .nto(nto), .settled(settled), .oscerr(oscerr), .setupviol(setupviol));

   always #5 u = ~u;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset;
      mga = ALL; mgb = ALL; mgc = ALL; mgd = NONE; mge = ALL; mgf = NONE;
      mnto = 4*W; msettled = 0; moscerr = 0; mviol = 0;
      n = 0; last_chg = 0; last_ok = 0; last_d = 0; last_t = 0;
      mdlast = NONE; mtlast = 0;
   endtask

   // Gate equations straight from the NAND table; monitors from edge timestamps.
   task automatic model_edge;
      logic [W-1:0] x, na, nb, nc, nd, ne, nf;
      logic pre_settled, dchg, trise;
      x  = d & {W{sc}};
      na = ~(x & mgb & {W{pc}});
      nb = ~(mga & {W{t}} & mgc);
      nc = ~({W{t}} & mgd & {W{pc}});
      nd = ~(mgc & mga & {W{ps}});
      ne = ~(mgb & mgf & {W{pc}});
      nf = ~(mgc & mge & {W{ps}});
      mnto = $countones({mga, mgb, mgc, mgd, mge, mgf});
      n++;
      if ({na, nb, nc, nd, ne, nf} != {mga, mgb, mgc, mgd, mge, mgf}) last_chg = n;
      {mga, mgb, mgc, mgd, mge, mgf} = {na, nb, nc, nd, ne, nf};
      pre_settled = msettled;
      msettled = (n - last_chg) >= SETTLE;
      if (pre_settled) last_ok = n;
      else if (n - last_ok >= MAXOSC) moscerr = 1;
      dchg = d != mdlast;
      trise = t && !mtlast;
      if (dchg) last_d = n;
      if (trise) last_t = n;
      if ((trise && (n - last_d) < SETUP) || (dchg && (n - last_t) < HOLD)) mviol = 1;
      mdlast = d;
      mtlast = t;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":Q"}, q, mgf);
      chk({tag, ":_Q"}, qn, mge);
      chk({tag, ":gates"}, {ga, gb, gc, gd, ge, gf}, {mga, mgb, mgc, mgd, mge, mgf});
      chk({tag, ":nto"}, nto, mnto);
      chk({tag, ":settled"}, settled, msettled);
      chk({tag, ":oscerr"}, oscerr, moscerr);
      chk({tag, ":setupviol"}, setupviol, mviol);
   endtask

   task automatic step(input string tag);
      @(posedge u);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Called just after a step: asserts RESET between edges and checks before the next edge.
   task automatic pulse_reset(input string tag);
      #1 rst = 1;
      mreset();
      #1;
      chk({tag, ":rst_Q"}, q, NONE);
      chk({tag, ":rst__Q"}, qn, ALL);
      chk({tag, ":rst_gates"}, {ga, gb, gc, gd, ge, gf}, {ALL, ALL, ALL, NONE, ALL, NONE});
      chk({tag, ":rst_nto"}, nto, 4*W);
      chk({tag, ":rst_flags"}, {settled, oscerr, setupviol}, 3'b000);
      #1 rst = 0;
      d = NONE; t = 0; pc = 1; ps = 1; sc = 1;
   endtask

   initial begin
      mreset();
      #1 rst = 1;
      #8;
      check_all("init");
      chk("init_nto", nto, 48);
      #3 rst = 0;
      for (int i = 1; i <= 5; i++) begin
         step("idle");
         if (i == 2) chk("settled_e2", settled, 0);
         if (i == 3) chk("settled_e3", settled, 1);
      end
      chk("idle_Q", q, 0);
      chk("idle__Q", qn, 12'hFFF);
      chk("idle_nto", nto, 48);
      d = 12'hA5A;
      repeat (4) step("setup");
      t = 1;
      step("cap_k");
      step("cap_k1");
      step("cap_k2");
      chk("cap_Q", q, 12'hA5A);
      chk("cap__Q", qn, 12'h5A5);
      d = 12'h3C3;
      step("hold_k3");
      chk("hold_Q", q, 12'hA5A);
      chk("hold_viol", setupviol, 0);
      step("hold_k4");
      chk("hold_Q2", q, 12'hA5A);
      t = 0;
      repeat (2) step("tlow");
      d = 12'h0F0; t = 1;
      step("simul");
      chk("simul_viol", setupviol, 1);
      repeat (2) step("sticky");
      chk("sticky_viol", setupviol, 1);
      pulse_reset("r1");
      ps = 0;
      repeat (4) step("preset");
      chk("preset_Q", q, 12'hFFF);
      ps = 1; pc = 0;
      repeat (4) step("preclr");
      chk("preclr_Q", q, 12'h000);
      ps = 0;
      repeat (4) step("both");
      chk("both_Q", q, 12'hFFF);
      chk("both__Q", qn, 12'hFFF);
      pc = 1; ps = 1;
      repeat (4) step("release");
      pulse_reset("r2");
      for (int i = 1; i <= MAXOSC; i++) begin
         d = ~d; t = ~t;
         step("osc");
         chk("osc_settled", settled, 0);
         if (i == MAXOSC - 1) chk("osc_pre", oscerr, 0);
         if (i == MAXOSC) chk("osc_err", oscerr, 1);
      end
      pulse_reset("r3");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) d = W'($urandom);
         if ($urandom_range(0, 3) == 0) t = ~t;
         pc = $urandom_range(0, 9) != 0;
         ps = $urandom_range(0, 9) != 0;
         sc = $urandom_range(0, 5) != 0;
         step("rnd");
         if (i % 100 == 99) pulse_reset("rnd_rst");
      end
      d = ALL;
      repeat (4) step("pre_abort");
      t = 1;
      step("abort_k");
      pulse_reset("abort");
      repeat (4) step("post_abort");
      chk("post_abort_Q", q, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
